// File: rtl/rs422_uart_tx.sv
// rs422_uart_tx: 8N1 UART transmitter that drives RS-422/RS-485 transceiver pins.
// The driver enable (rs422_de) is raised only around a frame: an optional lead guard,
// then start, data and stop bits, then an optional tail guard. Outside that window the
// bus is released so that other nodes can drive it.
module rs422_uart_tx #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int DE_LEAD       = 16,
    parameter int DE_TAIL_BITS  = 1,
    parameter int ECHO_SUPPRESS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       rs422_txd,
    output logic       rs422_de,
    output logic       rs422_re_n,
    output logic       rs422_te,
    output logic       busy
);

    localparam int TAIL_LEN  = DE_TAIL_BITS * CLKS_PER_BIT;
    localparam int CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LW        = (DE_LEAD > 1) ? $clog2(DE_LEAD) : 1;
    localparam int TW        = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;
    localparam int LEAD_LAST = (DE_LEAD > 0) ? DE_LEAD - 1 : 0;
    localparam int TAIL_LAST = (TAIL_LEN > 0) ? TAIL_LEN - 1 : 0;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LEAD_END  = LW'(LEAD_LAST);
    localparam logic [TW-1:0] TAIL_END  = TW'(TAIL_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_START,
        S_DATA,
        S_STOP,
        S_TAIL
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;      // clocks within the current bit
    logic [2:0]      bit_q, bit_n;      // data bit index
    logic [LW-1:0]   lead_q, lead_n;    // lead guard clocks
    logic [TW-1:0]   tail_q, tail_n;    // tail guard clocks
    logic [7:0]      shreg_q, shreg_n;  // byte being sent, LSB on the line
    logic            txd_q, txd_n;
    logic            de_q, de_n;
    logic            busy_q;
    logic            bit_end;

    assign bit_end = (cnt_q == BIT_LAST);

    // Ready is decoded from state so a tail-state accept can chain frames seamlessly.
    assign in_ready   = (state_q == S_IDLE) || (state_q == S_TAIL);
    assign rs422_txd  = txd_q;
    assign rs422_de   = de_q;
    assign rs422_re_n = (ECHO_SUPPRESS != 0) ? de_q : 1'b0;
    assign rs422_te   = 1'b0;
    assign busy       = busy_q;

    // Next-state and next-output decode; outputs are computed for the state being entered.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        lead_n  = lead_q;
        tail_n  = tail_q;
        shreg_n = shreg_q;
        txd_n   = 1'b1;
        de_n    = 1'b1;
        case (state_q)
            S_IDLE: begin
                de_n = 1'b0;
                if (in_valid) begin
                    shreg_n = in_data;
                    de_n    = 1'b1;
                    cnt_n   = '0;
                    lead_n  = '0;
                    if (DE_LEAD == 0) begin
                        state_n = S_START;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = S_LEAD;
                    end
                end
            end
            S_LEAD: begin
                if (lead_q == LEAD_END) begin
                    state_n = S_START;
                    txd_n   = 1'b0;
                    cnt_n   = '0;
                end else begin
                    lead_n = lead_q + 1'b1;
                end
            end
            S_START: begin
                txd_n = 1'b0;
                if (bit_end) begin
                    state_n = S_DATA;
                    cnt_n   = '0;
                    bit_n   = '0;
                    txd_n   = shreg_q[0];
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                txd_n = shreg_q[0];
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_q == 3'd7) begin
                        state_n = S_STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n   = bit_q + 1'b1;
                        shreg_n = {1'b0, shreg_q[7:1]};
                        txd_n   = shreg_q[1];
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_n  = '0;
                    tail_n = '0;
                    if (TAIL_LEN == 0) begin
                        state_n = S_IDLE;
                        de_n    = 1'b0;
                    end else begin
                        state_n = S_TAIL;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            S_TAIL: begin
                // A new byte here skips the lead guard: DE is already up.
                if (in_valid) begin
                    shreg_n = in_data;
                    state_n = S_START;
                    txd_n   = 1'b0;
                    cnt_n   = '0;
                end else if (tail_q == TAIL_END) begin
                    state_n = S_IDLE;
                    de_n    = 1'b0;
                end else begin
                    tail_n = tail_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                de_n    = 1'b0;
            end
        endcase
    end

    // State, counters and registered pin outputs; reset releases the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            lead_q  <= '0;
            tail_q  <= '0;
            shreg_q <= '0;
            txd_q   <= 1'b1;
            de_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            lead_q  <= lead_n;
            tail_q  <= tail_n;
            shreg_q <= shreg_n;
            txd_q   <= txd_n;
            de_q    <= de_n;
            busy_q  <= (state_n != S_IDLE);
        end
    end

endmodule
